// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// vga_if : VGA timing + colour bundle passed between pipeline stages
// Rev 1.0
// ============================================================================
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out    (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in     (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport master (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport slave  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_text_box.sv
`default_nettype none
// ============================================================================
// draw_text_box : COLS x ROWS glyph overlay with scaling and font-ROM latency
// Optional blinking glyphs when DRAW_TEXT_BLINK_EN is defined.  Rev 1.0
// ============================================================================
module draw_text_box #(
  parameter int          X_POS       = 64,
  parameter int          Y_POS       = 32,
  parameter int          COLS        = 16,
  parameter int          ROWS        = 4,
  parameter int          SCALE_LOG2  = 0,
  parameter int          ROM_LAT     = 1,
  parameter logic [11:0] FG_COLOR    = 12'hFFF,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter bit          TRANSPARENT = 1'b0,
  localparam int         AW          = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef DRAW_TEXT_BLINK_EN
  input  logic          blink,
`endif
  input  logic [7:0]    char_pixels,
  vga_if.in             in,
  vga_if.out            out,
  output logic [AW-1:0] char_addr,
  output logic [3:0]    char_line
);

  localparam logic [31:0] C_X_LO = 32'(X_POS);
  localparam logic [31:0] C_Y_LO = 32'(Y_POS);
  localparam logic [31:0] C_X_HI = C_X_LO + 32'(COLS * 8 * (1 << SCALE_LOG2));
  localparam logic [31:0] C_Y_HI = C_Y_LO + 32'(ROWS * 16 * (1 << SCALE_LOG2));

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
    logic        in_box;
    logic [2:0]  bit_sel;
  } stage_t;

  logic [10:0] w_rx;
  logic [10:0] w_ry;
  logic        w_in_box;
  stage_t      stage_d;
  stage_t      pipe_q [ROM_LAT];
  stage_t      w_last;
  logic        vblnk_q;
  logic        en_q;
  logic        w_box_hit;
  logic        w_glyph;
  logic [11:0] rgb_d;

  always_comb begin
    w_in_box = ({21'd0, in.hcount} >= C_X_LO) && ({21'd0, in.hcount} < C_X_HI) &&
               ({21'd0, in.vcount} >= C_Y_LO) && ({21'd0, in.vcount} < C_Y_HI);
    w_rx = (in.hcount - C_X_LO[10:0]) >> SCALE_LOG2;
    w_ry = (in.vcount - C_Y_LO[10:0]) >> SCALE_LOG2;
    // Outside the box the ROM address is parked at 0 so it never leaves range
    char_addr = '0;
    char_line = '0;
    if (w_in_box) begin
      char_addr = AW'(32'(w_ry[10:4]) * 32'(COLS) + 32'(w_rx[10:3]));
      char_line = w_ry[3:0];
    end
    stage_d.vcount  = in.vcount;
    stage_d.vsync   = in.vsync;
    stage_d.vblnk   = in.vblnk;
    stage_d.hcount  = in.hcount;
    stage_d.hsync   = in.hsync;
    stage_d.hblnk   = in.hblnk;
    stage_d.rgb     = in.rgb;
    stage_d.in_box  = w_in_box;
    stage_d.bit_sel = ~w_rx[2:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef DRAW_TEXT_BLINK_EN
  logic [7:0] frame_cnt_q;
  logic       blink_q;
`endif

  // Enable (and blink) only change on the rising edge of vertical blanking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q     <= 1'b0;
      en_q        <= 1'b0;
`ifdef DRAW_TEXT_BLINK_EN
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
`endif
    end else begin
      vblnk_q <= in.vblnk;
      if (in.vblnk && !vblnk_q) begin
        en_q        <= en;
`ifdef DRAW_TEXT_BLINK_EN
        frame_cnt_q <= frame_cnt_q + 8'd1;
        blink_q     <= blink;
`endif
      end
    end
  end

  always_comb begin
    w_last    = pipe_q[ROM_LAT-1];
    w_box_hit = w_last.in_box && en_q && !w_last.hblnk && !w_last.vblnk;
`ifdef DRAW_TEXT_BLINK_EN
    w_glyph   = char_pixels[w_last.bit_sel] && !(blink_q && frame_cnt_q[5]);
`else
    w_glyph   = char_pixels[w_last.bit_sel];
`endif
    rgb_d = w_last.rgb;
    if (w_box_hit) rgb_d = w_glyph ? FG_COLOR : (TRANSPARENT ? w_last.rgb : BG_COLOR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= w_last.vcount;
      out.vsync  <= w_last.vsync;
      out.vblnk  <= w_last.vblnk;
      out.hcount <= w_last.hcount;
      out.hsync  <= w_last.hsync;
      out.hblnk  <= w_last.hblnk;
      out.rgb    <= rgb_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_text_box.sv
`default_nettype none
// ============================================================================
// tb_draw_text_box : randomized scoreboard bench, two configurations of the box
// Rev 1.0
// ============================================================================
module tb_draw_text_box;
  localparam int X0 = 64,  Y0 = 32, C0 = 16, R0 = 4, S0 = 0, L0 = 1;
  localparam int X1 = 100, Y1 = 20, C1 = 8,  R1 = 3, S1 = 1, L1 = 3;
  localparam logic [11:0] FG0 = 12'hFFF, BG0 = 12'h000, FG1 = 12'hABC, BG1 = 12'h123;
  localparam bit T0 = 1'b0, T1 = 1'b1;

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } pix_t;

  typedef struct {
    int   due;
    pix_t exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] px0, px1;
  logic [5:0] addr0;
  logic [4:0] addr1;
  logic [3:0] line0, line1;
`ifdef DRAW_TEXT_BLINK_EN
  logic       blink = 1'b0;
`endif

  vga_if vin ();
  vga_if vo0 ();
  vga_if vo1 ();

  draw_text_box #(.X_POS(X0), .Y_POS(Y0), .COLS(C0), .ROWS(R0), .SCALE_LOG2(S0), .ROM_LAT(L0),
                  .FG_COLOR(FG0), .BG_COLOR(BG0), .TRANSPARENT(T0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en),
`ifdef DRAW_TEXT_BLINK_EN
    .blink(blink),
`endif
    .char_pixels(px0), .in(vin), .out(vo0), .char_addr(addr0), .char_line(line0));

  draw_text_box #(.X_POS(X1), .Y_POS(Y1), .COLS(C1), .ROWS(R1), .SCALE_LOG2(S1), .ROM_LAT(L1),
                  .FG_COLOR(FG1), .BG_COLOR(BG1), .TRANSPARENT(T1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en),
`ifdef DRAW_TEXT_BLINK_EN
    .blink(blink),
`endif
    .char_pixels(px1), .in(vin), .out(vo1), .char_addr(addr1), .char_line(line1));

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] font(input int a, input int l);
    int t;
    t = a * 73 + l * 29 + 13;
    return 8'(t ^ (t >> 5) ^ (a * l));
  endfunction

  // Font ROMs with the latency each instance is configured for
  logic [7:0] rom0_q = 8'h00;
  logic [7:0] rom1_q [3] = '{default: 8'h00};
  always @(posedge clk) begin
    rom0_q    <= font(int'(addr0), int'(line0));
    rom1_q[0] <= font(int'(addr1), int'(line1));
    rom1_q[1] <= rom1_q[0];
    rom1_q[2] <= rom1_q[1];
  end
  assign px0 = rom0_q;
  assign px1 = rom1_q[2];

  function automatic void geom(input int xp, yp, cols, rows, sl, h, v,
                               output bit inb, output int a, output int l, output int x);
    int rx, ry;
    inb = (h >= xp) && (h < xp + ((cols * 8) << sl)) && (v >= yp) && (v < yp + ((rows * 16) << sl));
    a = 0; l = 0; x = 0;
    if (inb) begin
      rx = (h - xp) >> sl;
      ry = (v - yp) >> sl;
      a  = (ry / 16) * cols + rx / 8;
      l  = ry % 16;
      x  = rx % 8;
    end
  endfunction

  function automatic logic [11:0] exp_rgb(input int xp, yp, cols, rows, sl,
                                          input logic [11:0] fg, bg, input bit tr,
                                          input pix_t p, input bit enm, input bit hide);
    bit inb;
    int a, l, x;
    logic [7:0] g;
    geom(xp, yp, cols, rows, sl, int'(p.hcount), int'(p.vcount), inb, a, l, x);
    g = font(a, l);
    if (!(inb && enm && !p.hblnk && !p.vblnk)) return p.rgb;
    if (g[7 - x] && !hide) return fg;
    return tr ? p.rgb : bg;
  endfunction

  sb_t  q0[$], q1[$];
  int   vectors = 0, errors = 0;
  bit   prev_vb = 1'b0, en_m = 1'b0, en_req = 1'b0;
  bit   blink_m = 1'b0, blink_req = 1'b0;
  logic [7:0] cnt_m = 8'd0;

  task automatic check_px(input string nm, input sb_t e, input pix_t got);
    vectors++;
    if (e.due != cyc || got != e.exp) begin
      errors++;
      $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", nm, cyc, e.due, got, e.exp);
    end
  endtask

  // Monitor: pops each expected pixel when its output cycle arrives
  initial forever begin
    pix_t g0, g1;
    @(negedge clk);
    g0 = {vo0.vcount, vo0.vsync, vo0.vblnk, vo0.hcount, vo0.hsync, vo0.hblnk, vo0.rgb};
    g1 = {vo1.vcount, vo1.vsync, vo1.vblnk, vo1.hcount, vo1.hsync, vo1.hblnk, vo1.rgb};
    if (q0.size() > 0 && q0[0].due <= cyc) check_px("pix0", q0.pop_front(), g0);
    if (q1.size() > 0 && q1[0].due <= cyc) check_px("pix1", q1.pop_front(), g1);
  end

  task automatic chk_zero(input string nm);
    pix_t g0, g1;
    g0 = {vo0.vcount, vo0.vsync, vo0.vblnk, vo0.hcount, vo0.hsync, vo0.hblnk, vo0.rgb};
    g1 = {vo1.vcount, vo1.vsync, vo1.vblnk, vo1.hcount, vo1.hsync, vo1.hblnk, vo1.rgb};
    vectors += 2;
    if (g0 != '0) begin errors++; $display("FAIL %s dut0 got=%h want=0", nm, g0); end
    if (g1 != '0) begin errors++; $display("FAIL %s dut1 got=%h want=0", nm, g1); end
  endtask

  task automatic apply(input logic [10:0] h, v, input logic hs, vs, hb, vb);
    pix_t p, e0, e1;
    bit   inb, hide;
    int   a, l, x;
    @(posedge clk);
    #1;
    p.vcount = v; p.vsync = vs; p.vblnk = vb;
    p.hcount = h; p.hsync = hs; p.hblnk = hb;
    p.rgb    = 12'($urandom);
    vin.vcount = v; vin.vsync = vs; vin.vblnk = vb;
    vin.hcount = h; vin.hsync = hs; vin.hblnk = hb;
    vin.rgb    = p.rgb;
    en = en_req;
    hide = 1'b0;
`ifdef DRAW_TEXT_BLINK_EN
    blink = blink_req;
    hide  = blink_m && cnt_m[5];
`endif
    e0 = p; e0.rgb = exp_rgb(X0, Y0, C0, R0, S0, FG0, BG0, T0, p, en_m, hide);
    e1 = p; e1.rgb = exp_rgb(X1, Y1, C1, R1, S1, FG1, BG1, T1, p, en_m, hide);
    q0.push_back('{cyc + L0 + 1, e0});
    q1.push_back('{cyc + L1 + 1, e1});
    #1;
    geom(X0, Y0, C0, R0, S0, int'(h), int'(v), inb, a, l, x);
    vectors++;
    if (int'(addr0) != a || int'(line0) != l) begin
      errors++;
      $display("FAIL addr0 h=%0d v=%0d got=%0d/%0d want=%0d/%0d", h, v, addr0, line0, a, l);
    end
    geom(X1, Y1, C1, R1, S1, int'(h), int'(v), inb, a, l, x);
    vectors++;
    if (int'(addr1) != a || int'(line1) != l) begin
      errors++;
      $display("FAIL addr1 h=%0d v=%0d got=%0d/%0d want=%0d/%0d", h, v, addr1, line1, a, l);
    end
    if (vb && !prev_vb) begin
      en_m    = en_req;
      blink_m = blink_req;
      cnt_m++;
    end
    prev_vb = vb;
  endtask

  function automatic logic [10:0] rh();
    if ($urandom_range(0, 15) == 0) return 11'($urandom);
    return 11'($urandom_range(56, 239));
  endfunction

  function automatic logic [10:0] rv();
    if ($urandom_range(0, 15) == 0) return 11'($urandom);
    return 11'($urandom_range(14, 123));
  endfunction

  task automatic vblank();
    repeat (4) apply(rh(), rv(), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    repeat (4) apply(rh(), rv(), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    repeat (2) apply(rh(), rv(), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    q0.delete();
    q1.delete();
    en_m = 1'b0; blink_m = 1'b0; cnt_m = 8'd0; prev_vb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst = 1'b1;
  endtask

  int dh[12] = '{64, 71, 88, 191, 192, 63, 100, 227, 228, 100, 135, 2047};
  int dv[12] = '{32, 32, 66, 95,  40,  40, 20,  115, 60,  116, 50,  40};

  initial begin
    vin.vcount = '0; vin.vsync = 1'b0; vin.vblnk = 1'b0;
    vin.hcount = '0; vin.hsync = 1'b0; vin.hblnk = 1'b0; vin.rgb = '0;
    #2;
    chk_zero("rst_init");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    en_req = 1'b1;
    vblank();
    for (int i = 0; i < 12; i++) apply(11'(dh[i]), 11'(dv[i]), 1'b0, 1'b0, 1'b0, 1'b0);

    for (int f = 0; f < 140; f++) begin
      blink_req = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 24; i++) begin
        if ($urandom_range(0, 7) == 0) en_req = ($urandom_range(0, 3) != 0);
        if (f == 70 && i == 10) do_reset();
        apply(rh(), rv(), 1'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
      end
      vblank();
    end

    repeat (L1 + 3) @(posedge clk);
    #1;
    vectors++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
